alu_seq: RTL and testbench

- Sequential, parametrised successor to the CPU's 8-bit combinational ALU.
- Executes ADD/ADC/SUB/SBC/AND/XOR/OR/CP over WIDTH bits, SLICE bits per clock, LSB slice first.
- Owns a registered Z/N/H/C flag register; ADC/SBC take their carry-in from it.
- Sits between the CPU decoder/sequencer and the register file. The same block serves 8-bit A ops and 16-bit ADD HL-style ops.

---
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Slice-serial ALU with registered Z/N/H/C flags, SLICE bits per clock, LSB first.
// Optional decimal adjust (WIDTH=8 only) is enabled by defining ALU_DAA_EN.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter int SLICE  = 4,
   parameter int HC_BIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef ALU_DAA_EN
   input  logic             daa_start,
`endif
   output logic             ready,
   input  logic [2:0]       command,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             flags_load,
   input  logic [3:0]       flags_in,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             done
);

   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSL - 1);

   localparam logic [2:0] C_ADC = 3'b001;
   localparam logic [2:0] C_SBC = 3'b011;
   localparam logic [2:0] C_AND = 3'b100;
   localparam logic [2:0] C_XOR = 3'b101;
   localparam logic [2:0] C_OR  = 3'b110;
   localparam logic [2:0] C_CP  = 3'b111;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       cmd_q, cmd_d;
   logic [WIDTH-1:0] op1_q, op1_d;
   logic [WIDTH-1:0] op2_q, op2_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             cy_q, cy_d;
   logic             zero_q, zero_d;
   logic             h_q, h_d;
   logic             done_q, done_d;

   logic             is_sub, is_logic;
   logic [SLICE-1:0] sa, sb, sr;
   logic             c, h_o;
   int               base;

   assign is_sub   = (cmd_q[2:1] == 2'b01) || (cmd_q == C_CP);
   assign is_logic = cmd_q[2] && (cmd_q != C_CP);

   // Ripple one slice bit by bit so H can be tapped at any bit position.
   always_comb begin
      base = int'(cnt_q) * SLICE;
      sa   = op1_q[base +: SLICE];
      sb   = op2_q[base +: SLICE];
      sr   = '0;
      c    = cy_q;
      h_o  = h_q;
      for (int i = 0; i < SLICE; i++) begin
         sr[i] = sa[i] ^ sb[i] ^ c;
         if (is_sub)
            c = (~sa[i] & sb[i]) | (~sa[i] & c) | (sb[i] & c);
         else
            c = (sa[i] & sb[i]) | (sa[i] & c) | (sb[i] & c);
         if (base + i == HC_BIT)
            h_o = c;
      end
      if (cmd_q == C_AND)
         sr = sa & sb;
      else if (cmd_q == C_XOR)
         sr = sa ^ sb;
      else if (cmd_q == C_OR)
         sr = sa | sb;
   end

`ifdef ALU_DAA_EN
   logic [7:0] da;
   logic       dc;

   always_comb begin
      da = operand1[7:0];
      dc = flags_q[0];
      if (!flags_q[2]) begin
         if (flags_q[0] || operand1[7:0] > 8'h99) begin
            da = da + 8'h60;
            dc = 1'b1;
         end
         if (flags_q[1] || operand1[3:0] > 4'd9)
            da = da + 8'h06;
      end else begin
         if (flags_q[0])
            da = da - 8'h60;
         if (flags_q[1])
            da = da - 8'h06;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      acc_d    = acc_q;
      result_d = result_q;
      flags_d  = flags_q;
      cy_d     = cy_q;
      zero_d   = zero_q;
      h_d      = h_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef ALU_DAA_EN
            if (daa_start) begin
               result_d = WIDTH'(da);
               flags_d  = {da == 8'h00, flags_q[2], 1'b0, dc};
               done_d   = 1'b1;
            end else
`endif
            if (start) begin
               cmd_d   = command;
               op1_d   = operand1;
               op2_d   = operand2;
               cnt_d   = '0;
               acc_d   = '0;
               zero_d  = 1'b1;
               h_d     = 1'b0;
               cy_d    = 1'b0;
               if (command == C_ADC || command == C_SBC)
                  cy_d = flags_load ? flags_in[0] : flags_q[0];
               if (flags_load)
                  flags_d = flags_in;
               state_d = BUSY;
            end else if (flags_load) begin
               flags_d = flags_in;
            end
         end
         BUSY: begin
            acc_d[base +: SLICE] = sr;
            cy_d   = c;
            h_d    = h_o;
            zero_d = zero_q & ~(|sr);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = IDLE;
               cnt_d    = '0;
               done_d   = 1'b1;
               result_d = (cmd_q == C_CP) ? op1_q : acc_d;
               flags_d  = {zero_d, is_sub,
                           is_logic ? (cmd_q == C_AND) : h_o,
                           is_logic ? 1'b0 : c};
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cmd_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         cy_q     <= 1'b0;
         zero_q   <= 1'b0;
         h_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         cy_q     <= cy_d;
         zero_q   <= zero_d;
         h_q      <= h_d;
         done_q   <= done_d;
      end
   end

   assign ready  = (state_q == IDLE);
   assign result = result_q;
   assign flags  = flags_q;
   assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq: 8-bit/4-slice and 16-bit/8-slice builds.
// Decimal-adjust vectors run only when ALU_DAA_EN is defined.
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       rst8, start8, fl8, ready8, done8;
   logic [2:0] cmd8;
   logic [7:0] a8, b8, res8;
   logic [3:0] fin8, flg8;
   logic       daa8;

   logic        rst16, start16, fl16, ready16, done16;
   logic [2:0]  cmd16;
   logic [15:0] a16, b16, res16;
   logic [3:0]  fin16, flg16;
   logic        daa16;

   alu_seq u8 (
      .clk(clk), .rst(rst8), .start(start8),
`ifdef ALU_DAA_EN
      .daa_start(daa8),
`endif
      .ready(ready8), .command(cmd8),
      .operand1(a8), .operand2(b8),
      .flags_load(fl8), .flags_in(fin8),
      .result(res8), .flags(flg8), .done(done8)
   );

   alu_seq #(.WIDTH(16), .SLICE(8), .HC_BIT(11)) u16 (
      .clk(clk), .rst(rst16), .start(start16),
`ifdef ALU_DAA_EN
      .daa_start(daa16),
`endif
      .ready(ready16), .command(cmd16),
      .operand1(a16), .operand2(b16),
      .flags_load(fl16), .flags_in(fin16),
      .result(res16), .flags(flg16), .done(done16)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
      logic       pl;
      logic       ls;
      logic [3:0] fin;
      logic [7:0] er;
      logic [3:0] ef;
   } vec_t;

   vec_t tbl[11];

   task automatic run8(input logic [2:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ls,
                       input logic [3:0] fin, output int lat);
      @(negedge clk);
      cmd8 = c; a8 = a; b8 = b;
      fl8 = ls; fin8 = fin; start8 = 1'b1;
      @(posedge clk); #1;
      chk("ready_low_busy", ready8, 1'b0);
      @(negedge clk);
      start8 = 1'b0; fl8 = 1'b0;
      a8 = ~a; b8 = ~b; fin8 = ~fin;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (done8) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run16(input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] b, output int lat);
      @(negedge clk);
      cmd16 = c; a16 = a; b16 = b; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat;
   int nd;

   initial begin
      tbl[0]  = '{3'b000, 8'h3A, 8'hC6, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1011};
      tbl[1]  = '{3'b010, 8'h3E, 8'h3E, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1100};
      tbl[2]  = '{3'b010, 8'h3E, 8'h40, 1'b0, 1'b0, 4'h0, 8'hFE, 4'b0101};
      tbl[3]  = '{3'b001, 8'hE1, 8'h0F, 1'b1, 1'b0, 4'h1, 8'hF1, 4'b0010};
      tbl[4]  = '{3'b100, 8'hF0, 8'h0F, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1010};
      tbl[5]  = '{3'b101, 8'hFF, 8'h0F, 1'b0, 1'b0, 4'h0, 8'hF0, 4'b0000};
      tbl[6]  = '{3'b110, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1000};
      tbl[7]  = '{3'b011, 8'h10, 8'h01, 1'b0, 1'b1, 4'h1, 8'h0E, 4'b0110};
      tbl[8]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1011};
      tbl[9]  = '{3'b001, 8'h00, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 4'b1000};
      tbl[10] = '{3'b011, 8'h05, 8'h03, 1'b1, 1'b0, 4'h1, 8'h01, 4'b0100};

      rst8 = 1'b1; start8 = 1'b0; fl8 = 1'b0; cmd8 = '0;
      a8 = '0; b8 = '0; fin8 = '0; daa8 = 1'b0;
      rst16 = 1'b1; start16 = 1'b0; fl16 = 1'b0; cmd16 = '0;
      a16 = '0; b16 = '0; fin16 = '0; daa16 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", res8, 8'h00);
      chk("rst_flags", flg8, 4'h0);
      chk("rst_done", done8, 1'b0);
      chk("rst_ready", ready8, 1'b1);
      @(negedge clk);
      rst8 = 1'b0; rst16 = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if (tbl[i].pl) begin
            @(negedge clk);
            fl8 = 1'b1; fin8 = tbl[i].fin;
            @(posedge clk); #1;
            chk($sformatf("v%0d_preload", i), flg8, tbl[i].fin);
            @(negedge clk);
            fl8 = 1'b0;
         end
         run8(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].ls, tbl[i].fin, lat);
         chk($sformatf("v%0d_latency", i), lat, 2);
         chk($sformatf("v%0d_result", i), res8, tbl[i].er);
         chk($sformatf("v%0d_flags", i), flg8, tbl[i].ef);
         chk($sformatf("v%0d_ready_done", i), ready8, 1'b1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), done8, 1'b0);
      end

      // CP with a second start while busy: one done, CP result kept
      @(negedge clk);
      cmd8 = 3'b111; a8 = 8'h3C; b8 = 8'h2F; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd8 = 3'b000; a8 = 8'h01; b8 = 8'h01;
      @(posedge clk); #1;
      chk("cp_busy_ready", ready8, 1'b0);
      @(negedge clk);
      start8 = 1'b0;
      nd = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done8) begin
            nd++;
            chk("cp_result", res8, 8'h3C);
            chk("cp_flags", flg8, 4'b0110);
         end
      end
      chk("cp_single_done", nd, 1);

`ifdef ALU_DAA_EN
      @(negedge clk);
      fl8 = 1'b1; fin8 = 4'b0000;
      @(negedge clk);
      fl8 = 1'b0; a8 = 8'h7D; daa8 = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      chk("daa1_done", done8, 1'b1);
      chk("daa1_result", res8, 8'h83);
      chk("daa1_flags", flg8, 4'b0000);
      chk("daa1_ready", ready8, 1'b1);
      @(negedge clk);
      daa8 = 1'b0; start8 = 1'b0;
      fl8 = 1'b1; fin8 = 4'b0001;
      @(negedge clk);
      fl8 = 1'b0; a8 = 8'h00; daa8 = 1'b1;
      @(posedge clk); #1;
      chk("daa2_result", res8, 8'h60);
      chk("daa2_flags", flg8, 4'b0001);
      @(negedge clk);
      daa8 = 1'b0;
      fl8 = 1'b1; fin8 = 4'b0111;
      @(negedge clk);
      fl8 = 1'b0; a8 = 8'h9A; daa8 = 1'b1;
      @(posedge clk); #1;
      chk("daa3_result", res8, 8'h34);
      chk("daa3_flags", flg8, 4'b0101);
      @(negedge clk);
      daa8 = 1'b0;
`endif

      run16(3'b000, 16'h0FFF, 16'h0001, lat);
      chk("w16_add_latency", lat, 2);
      chk("w16_add_result", res16, 16'h1000);
      chk("w16_add_flags", flg16, 4'b0010);
      run16(3'b010, 16'h1000, 16'h0001, lat);
      chk("w16_sub_latency", lat, 2);
      chk("w16_sub_result", res16, 16'h0FFF);
      chk("w16_sub_flags", flg16, 4'b0110);

      // Reset in the middle of a 16-bit operation
      @(negedge clk);
      cmd16 = 3'b000; a16 = 16'h1234; b16 = 16'h1111; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      rst16 = 1'b1;
      #1;
      chk("w16_rst_ready", ready16, 1'b1);
      chk("w16_rst_done", done16, 1'b0);
      chk("w16_rst_flags", flg16, 4'h0);
      chk("w16_rst_result", res16, 16'h0000);
      @(negedge clk);
      rst16 = 1'b0;
      nd = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done16) nd++;
      end
      chk("w16_rst_no_done", nd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
